// File: rtl/miriscv_mdu_pkg.sv
// Shared types for the iterative multiply-divide unit: op encoding (RV funct3) and FSM states.
package miriscv_mdu_pkg;

    localparam int unsigned MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } mdu_state_e;

    // funct3[2] separates the divide/remainder group from the multiplies
    function automatic logic mdu_op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/miriscv_mdu_div_core.sv
// Restoring divider datapath on unsigned magnitudes; one quotient bit per step_i, sequenced by the parent.
module miriscv_mdu_div_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            // Top bit of the trial difference is the borrow: restore on borrow
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/miriscv_mdu_iter.sv
// Iterative RV32M/RV64M multiply-divide unit with req/ready accept, kill and 1-cycle valid pulse.
// Define MIRISCV_MDU_DIV_ZERO_FAST_EN to finish divide-by-zero straight from accept.
module miriscv_mdu_iter
    import miriscv_mdu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mdu_req_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic [XLEN-1:0]     mdu_port_a_i,
    input  logic [XLEN-1:0]     mdu_port_b_i,
    input  logic                mdu_kill_i,
    output logic                mdu_ready_o,
    output logic                mdu_valid_o,
    output logic [XLEN-1:0]     mdu_result_o
);

    localparam int unsigned CntW      = $clog2(XLEN);
    localparam int unsigned MulCycles = XLEN / MUL_STEP;

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q, op_d, op_in;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d, a_neg_q, a_neg_d, dz_q, dz_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mul_add, prod_fix;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;
    logic              accept, a_signed, b_signed, sign_a, sign_b, b_zero;
    logic [XLEN-1:0]   abs_a, abs_b, quo, rem, quo_fix, rem_fix;
    logic              div_load, div_step;

    assign op_in    = mdu_op_e'(mdu_op_i);
    assign accept   = mdu_req_i & (state_q == IDLE) & ~mdu_kill_i;
    assign a_signed = (op_in inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
    assign b_signed = (op_in inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM});
    assign sign_a   = a_signed & mdu_port_a_i[XLEN-1];
    assign sign_b   = b_signed & mdu_port_b_i[XLEN-1];
    assign abs_a    = sign_a ? -mdu_port_a_i : mdu_port_a_i;
    assign abs_b    = sign_b ? -mdu_port_b_i : mdu_port_b_i;
    assign b_zero   = (mdu_port_b_i == '0);

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -quo : quo;
    assign rem_fix  = a_neg_q ? -rem : rem;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        dz_d     = dz_q;
        a_d      = a_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        valid_d  = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        mul_add  = '0;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) mul_add = mul_add + (mcand_q << i);
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = op_in;
                    neg_d    = sign_a ^ sign_b;
                    a_neg_d  = sign_a;
                    dz_d     = mdu_op_is_div(op_in) & b_zero;
                    a_d      = mdu_port_a_i;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    div_load = 1'b1;
                    if (!mdu_op_is_div(op_in)) begin
                        state_d = MUL;
                    end else begin
                        state_d = DIV;
`ifdef MIRISCV_MDU_DIV_ZERO_FAST_EN
                        if (b_zero) state_d = DONE;
`endif
                    end
                end
            end
            MUL: begin
                if (mdu_kill_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_q + mul_add;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(MulCycles - 1)) state_d = DONE;
                end
            end
            DIV: begin
                if (mdu_kill_i) begin
                    state_d = IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(XLEN - 1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                // Divide-by-zero results are forced here, never taken from the datapath
                unique case (op_q)
                    MDU_MUL:                         result_d = prod_fix[XLEN-1:0];
                    MDU_MULH, MDU_MULHSU, MDU_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    MDU_DIV, MDU_DIVU:               result_d = dz_q ? '1 : quo_fix;
                    MDU_REM, MDU_REMU:               result_d = dz_q ? a_q : rem_fix;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            dz_q     <= dz_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    miriscv_mdu_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (abs_a),
        .divisor_i   (abs_b),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    assign mdu_ready_o  = (state_q == IDLE);
    assign mdu_valid_o  = valid_q;
    assign mdu_result_o = result_q;

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
// Directed bench for miriscv_mdu_iter: XLEN=32/MUL_STEP=1, XLEN=32/MUL_STEP=4 and XLEN=64 instances.
module tb_miriscv_mdu_iter;
    import miriscv_mdu_pkg::*;

`ifdef MIRISCV_MDU_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic        kill;
    logic        no_kill;
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        rdy0, vld0, rdy1, vld1, rdy2, vld2;
    logic [31:0] res0, res1;
    logic [63:0] res2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    miriscv_mdu_iter #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk_i(clk), .rst_i(rst), .mdu_req_i(req[0]), .mdu_op_i(op),
        .mdu_port_a_i(a[31:0]), .mdu_port_b_i(b[31:0]), .mdu_kill_i(kill),
        .mdu_ready_o(rdy0), .mdu_valid_o(vld0), .mdu_result_o(res0)
    );

    miriscv_mdu_iter #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .mdu_req_i(req[1]), .mdu_op_i(op),
        .mdu_port_a_i(a[31:0]), .mdu_port_b_i(b[31:0]), .mdu_kill_i(no_kill),
        .mdu_ready_o(rdy1), .mdu_valid_o(vld1), .mdu_result_o(res1)
    );

    miriscv_mdu_iter #(.XLEN(64), .MUL_STEP(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .mdu_req_i(req[2]), .mdu_op_i(op),
        .mdu_port_a_i(a), .mdu_port_b_i(b), .mdu_kill_i(no_kill),
        .mdu_ready_o(rdy2), .mdu_valid_o(vld2), .mdu_result_o(res2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int sel, output logic v, output logic rdy, output logic [63:0] r);
        case (sel)
            0:       begin v = vld0; rdy = rdy0; r = {32'b0, res0}; end
            1:       begin v = vld1; rdy = rdy1; r = {32'b0, res1}; end
            default: begin v = vld2; rdy = rdy2; r = res2; end
        endcase
    endtask

    // Issue one op; lat counts rising edges after the accept edge until valid is seen
    task automatic run_op(input int sel, input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, output logic [63:0] res, output int lat,
                          output logic busy_ok);
        logic v, rdy;
        logic [63:0] r;
        @(negedge clk);
        op = o; a = x; b = y; req[sel] = 1'b1;
        @(posedge clk);
        #1 req[sel] = 1'b0;
        lat = 0; busy_ok = 1'b1; res = '0;
        while (lat < 200) begin
            @(posedge clk);
            #1 lat++;
            sample(sel, v, rdy, r);
            if (v) begin
                res = r;
                break;
            end
            if (rdy) busy_ok = 1'b0;
        end
        if (lat >= 200) check_eq("timeout", 64'(lat), 64'd0);
    endtask

    task automatic do_op(input string tag, input int sel, input logic [2:0] o,
                         input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] exp, input int exp_lat);
        logic [63:0] res;
        int lat;
        logic busy_ok;
        run_op(sel, o, x, y, res, lat, busy_ok);
        check_eq({tag, "_val"}, res, exp);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_busy"}, {63'b0, busy_ok}, 64'd1);
    endtask

    task automatic watch_no_valid(input string tag);
        int p = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (vld0) p++;
        end
        check_eq(tag, 64'(p), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1; req = '0; kill = 1'b0; no_kill = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {63'b0, rdy0}, 64'd1);
        check_eq("rst_valid", {63'b0, vld0}, 64'd0);
        check_eq("rst_result", {32'b0, res0}, 64'd0);
        rst = 1'b0;

        do_op("mul", 0, MDU_MUL, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 33);
        do_op("mulhu", 0, MDU_MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);
        do_op("mulh", 0, MDU_MULH, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0, 33);
        do_op("mulhsu", 0, MDU_MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33);
        do_op("mulhu4", 1, MDU_MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 9);
        do_op("mulh4", 1, MDU_MULH, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0, 9);
        do_op("mulhsu4", 1, MDU_MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 9);
        do_op("mul4", 1, MDU_MUL, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 9);

        do_op("div", 0, MDU_DIV, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33);
        do_op("rem", 0, MDU_REM, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33);
        do_op("divu", 0, MDU_DIVU, 64'd100, 64'd7, 64'd14, 33);
        do_op("remu", 0, MDU_REMU, 64'd100, 64'd7, 64'd2, 33);

        do_op("div0", 0, MDU_DIV, 64'd5, 64'd0, 64'hFFFFFFFF, ZLAT);
        do_op("rem0", 0, MDU_REM, 64'd5, 64'd0, 64'd5, ZLAT);
        do_op("divu0", 0, MDU_DIVU, 64'h80000000, 64'd0, 64'hFFFFFFFF, ZLAT);

        do_op("div_ovf", 0, MDU_DIV, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33);
        do_op("rem_ovf", 0, MDU_REM, 64'h80000000, 64'hFFFFFFFF, 64'h0, 33);
        do_op("div64_ovf", 2, MDU_DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
              64'h8000000000000000, 65);
        do_op("mulh64", 2, MDU_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'd4, 64'd3, 65);

        // Kill a divide in flight; previous result must be held
        held = res0;
        @(negedge clk);
        op = MDU_DIV; a = 64'd100; b = 64'd7; req[0] = 1'b1;
        @(posedge clk);
        #1 req[0] = 1'b0;
        check_eq("kill_accepted", {63'b0, rdy0}, 64'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check_eq("kill_ready", {63'b0, rdy0}, 64'd1);
        check_eq("kill_valid", {63'b0, vld0}, 64'd0);
        watch_no_valid("kill_no_valid");
        check_eq("kill_hold", {32'b0, res0}, {32'b0, held});
        do_op("mul_after_kill", 0, MDU_MUL, 64'd3, 64'd4, 64'd12, 33);

        // Kill together with req in IDLE must block the accept
        @(negedge clk);
        op = MDU_MUL; a = 64'd5; b = 64'd5; req[0] = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 req[0] = 1'b0; kill = 1'b0;
        check_eq("kill_idle_block", {63'b0, rdy0}, 64'd1);
        watch_no_valid("kill_idle_no_valid");

        // Reset in the middle of a multiply
        @(negedge clk);
        op = MDU_MUL; a = 64'd9; b = 64'd9; req[0] = 1'b1;
        @(posedge clk);
        #1 req[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_mid_ready", {63'b0, rdy0}, 64'd1);
        check_eq("rst_mid_result", {32'b0, res0}, 64'd0);
        check_eq("rst_mid_valid", {63'b0, vld0}, 64'd0);
        watch_no_valid("rst_mid_no_valid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
